// File: rtl/cam_hit_pkg.sv
// Shared types and helpers for the CAM hit-vector iterator.
// Compile-time option CAM_HIT_ITER_DESCEND_EN (see cam_hit_iter) selects scan order.
package cam_hit_pkg;

    localparam int CAM_WIDTH = 64;

    typedef logic [CAM_WIDTH-1:0]         cam_vec_t;
    typedef logic [$clog2(CAM_WIDTH)-1:0] cam_idx_t;
    typedef logic [$clog2(CAM_WIDTH):0]   cam_cnt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } cam_state_e;

    function automatic cam_cnt_t cam_popcount(input cam_vec_t v);
        cam_cnt_t n;
        n = '0;
        for (int i = 0; i < CAM_WIDTH; i++) begin
            n = n + cam_cnt_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cam_hit_prienc.sv
// Combinational find-first-set over a hit vector, lowest-first or highest-first,
// with any-set and exactly-one-set flags.
module cam_hit_prienc #(
    parameter int  WIDTH   = 64,
    parameter bit  DESCEND = 1'b0,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single
);

    // Last match in loop order wins, so the loop runs opposite to the priority.
    always_comb begin
        idx = '0;
        if (DESCEND) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

    assign any    = |vec;
    assign single = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/cam_hit_iter.sv
// Accepts a CAM hit vector, reports its popcount, then streams each hit index.
// Define CAM_HIT_ITER_DESCEND_EN to scan highest index first.
module cam_hit_iter
    import cam_hit_pkg::*;
#(
    parameter int  WIDTH = CAM_WIDTH,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vector,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [CNT_W-1:0] count,
    output logic             count_valid
);

`ifdef CAM_HIT_ITER_DESCEND_EN
    localparam bit DESCEND = 1'b1;
`else
    localparam bit DESCEND = 1'b0;
`endif

    cam_state_e       state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             count_valid_q, count_valid_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic             accept;

    cam_hit_prienc #(
        .WIDTH   (WIDTH),
        .DESCEND (DESCEND)
    ) u_prienc (
        .vec    (pending_q),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    assign in_ready    = (state_q == ST_IDLE) && !reset;
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == ST_SCAN) && enc_any;
    assign out_index   = enc_idx;
    assign out_last    = out_valid && enc_single;
    assign count       = count_q;
    assign count_valid = count_valid_q;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pending_d     = in_vector;
                    count_d       = CNT_W'(cam_popcount(cam_vec_t'(in_vector)));
                    count_valid_d = 1'b1;
                    // A zero vector produces no beats, so the block stays ready.
                    if (|in_vector) state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    pending_d[enc_idx] = 1'b0;
                    if (enc_single) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
        end
    end

endmodule

// File: tb/tb_cam_hit_iter.sv
// Scoreboard bench for cam_hit_iter: stimulus pushes expected counts and beats,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cam_hit_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_vector;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_index;
    logic        out_last;
    logic [6:0]  count;
    logic        count_valid;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_cnt[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    cam_hit_iter dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vector   (in_vector),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_last    (out_last),
        .count       (count),
        .count_valid (count_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push_beat(input int idx, input bit last);
        beat_t b;
        b.idx  = idx;
        b.last = last;
        exp_beats.push_back(b);
    endtask

    // Reference order of hit indices for an arbitrary vector.
    task automatic push_vec(input logic [63:0] v);
        int k;
        int n;
        k = 0;
        n = 0;
        for (int i = 0; i < 64; i++) if (v[i]) k++;
`ifdef CAM_HIT_ITER_DESCEND_EN
        for (int i = 63; i >= 0; i--) begin
`else
        for (int i = 0; i < 64; i++) begin
`endif
            if (v[i]) begin
                n++;
                push_beat(i, n == k);
            end
        end
    endtask

    task automatic send(input logic [63:0] v);
        in_valid  = 1'b1;
        in_vector = v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        flag("send_timeout");
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (exp_beats.size() == 0) return;
        end
        flag("drain_timeout");
    endtask

    // Monitor: compare whatever the DUT presents against the queue fronts.
    always @(negedge clk) begin
        beat_t b;
        if (!reset) begin
            if (count_valid) begin
                if (exp_cnt.size() == 0) flag("unexpected_count_valid");
                else chk("count", 64'(count), 64'(exp_cnt.pop_front()));
            end
            if (out_valid) begin
                if (exp_beats.size() == 0) begin
                    flag("unexpected_beat");
                end else begin
                    b = exp_beats[0];
                    chk("out_index", 64'(out_index), 64'(b.idx));
                    chk("out_last", 64'(out_last), 64'(b.last));
                    if (out_ready) void'(exp_beats.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vector = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_index", 64'(out_index), 0);
        chk("rst_out_last", 64'(out_last), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_count_valid", 64'(count_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 1);
        @(posedge clk);
        #1;

        // Two hits, timing of count and in_ready
        exp_cnt.push_back(2);
        push_vec(64'h00010000_00010000);
        send(64'h00010000_00010000);
        @(negedge clk);
        chk("t1_count", 64'(count), 2);
        chk("t1_count_valid", 64'(count_valid), 1);
        chk("t1_in_ready_scan0", 64'(in_ready), 0);
        @(negedge clk);
        chk("t1_in_ready_scan1", 64'(in_ready), 0);
        @(negedge clk);
        chk("t1_in_ready_idle", 64'(in_ready), 1);
        chk("t1_out_valid_idle", 64'(out_valid), 0);
        @(posedge clk);
        #1;

        // Five hits, hand-computed order
        exp_cnt.push_back(5);
`ifdef CAM_HIT_ITER_DESCEND_EN
        push_beat(56, 0); push_beat(48, 0); push_beat(36, 0); push_beat(16, 0); push_beat(0, 1);
`else
        push_beat(0, 0); push_beat(16, 0); push_beat(36, 0); push_beat(48, 0); push_beat(56, 1);
`endif
        send(64'h01010010_00010001);
        wait_drain(20);

        // Three back-to-back zero vectors
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_vector = '0;
        repeat (3) exp_cnt.push_back(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_in_ready", 64'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("zero_out_valid", 64'(out_valid), 0);
        chk("zero_count", 64'(count), 0);
        @(posedge clk);
        #1;

        // All ones with out_ready toggling
        out_ready = 1'b1;
        exp_cnt.push_back(64);
        push_vec(64'hFFFF_FFFF_FFFF_FFFF);
        send(64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("ones_count", 64'(count), 64);
        begin
            bit done;
            done = 1'b0;
            for (int i = 0; i < 400 && !done; i++) begin
                @(posedge clk);
                #1 out_ready = ~out_ready;
                if (exp_beats.size() == 0) done = 1'b1;
            end
            if (!done) flag("ones_drain_timeout");
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a scan
        exp_cnt.push_back(2);
`ifdef CAM_HIT_ITER_DESCEND_EN
        push_beat(63, 0);
`else
        push_beat(0, 0);
`endif
        send(64'h8000_0000_0000_0001);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 0);
        chk("mid_rst_out_last", 64'(out_last), 0);
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_count_valid", 64'(count_valid), 0);
        chk("mid_rst_in_ready", 64'(in_ready), 0);
        chk("mid_rst_first_beat_taken", 64'(exp_beats.size()), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready_after", 64'(in_ready), 1);
        chk("mid_rst_out_valid_after", 64'(out_valid), 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // New vector offered while scanning
        exp_cnt.push_back(2);
        push_vec(64'h00010000_00010000);
        send(64'h00010000_00010000);
        exp_cnt.push_back(3);
        push_vec(64'h7);
        in_valid  = 1'b1;
        in_vector = 64'h7;
        @(negedge clk);
        chk("busy_in_ready0", 64'(in_ready), 0);
        @(negedge clk);
        chk("busy_in_ready1", 64'(in_ready), 0);
        @(negedge clk);
        chk("busy_in_ready_release", 64'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("busy_second_count", 64'(count), 3);
        wait_drain(20);
        repeat (3) @(posedge clk);
        #1;

        chk("beats_left", 64'(exp_beats.size()), 0);
        chk("counts_left", 64'(exp_cnt.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
